// File: rtl/pipe_magnitude_comparator.sv
// Pipelined N-bit magnitude comparator, CHUNK bits per stage, MS slice first, signed/unsigned per compare.
// Latency: STAGES = N/CHUNK cycles from input transfer to out_valid; one result per cycle sustained.
// Backpressure: elastic valid/ready chain; in_ready is combinational from out_ready, stalled stages hold.
module pipe_magnitude_comparator #(
    parameter int N     = 16,
    parameter int CHUNK = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     X,
    input  logic [N-1:0]     Y,
    input  logic             is_signed,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             Less,
    output logic             More,
    output logic             Equal,
    output logic [TAG_W-1:0] tag_out
);

    localparam int STAGES = N / CHUNK;
    localparam int LAST   = STAGES - 1;

    logic [STAGES-1:0] vld, dec, lt;
    logic [TAG_W-1:0]  tag [STAGES];
    logic [N-1:0]      xr  [STAGES];
    logic [N-1:0]      yr  [STAGES];
    logic              seen;

    logic [STAGES-1:0] adv, load;
    logic [STAGES-1:0] src_vld, src_dec, src_lt, nxt_dec, nxt_lt;
    logic [TAG_W-1:0]  src_tag [STAGES];
    logic [N-1:0]      src_x   [STAGES];
    logic [N-1:0]      src_y   [STAGES];
    logic [CHUNK-1:0]  xs, ys;
    logic              unused_ops;

    // Ready ripples back from the output: a stage loads when empty or when it is moving on.
    always_comb begin
        adv       = '0;
        load      = '0;
        adv[LAST]  = vld[LAST] && out_ready;
        load[LAST] = !vld[LAST] || adv[LAST];
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k]  = vld[k] && load[k+1];
            load[k] = !vld[k] || adv[k];
        end
    end

    assign in_ready = load[0];

    always_comb begin
        src_vld    = '0;
        src_dec    = '0;
        src_lt     = '0;
        src_vld[0] = in_valid;
        src_tag[0] = tag_in;
        src_x[0]   = X;
        src_y[0]   = Y;
        // Flipping the sign bits turns a two's-complement compare into an unsigned one.
        src_x[0][N-1] = X[N-1] ^ is_signed;
        src_y[0][N-1] = Y[N-1] ^ is_signed;
        for (int k = 1; k < STAGES; k++) begin
            src_vld[k] = vld[k-1];
            src_dec[k] = dec[k-1];
            src_lt[k]  = lt[k-1];
            src_tag[k] = tag[k-1];
            src_x[k]   = xr[k-1];
            src_y[k]   = yr[k-1];
        end
        nxt_dec = src_dec;
        nxt_lt  = src_lt;
        xs      = '0;
        ys      = '0;
        for (int k = 0; k < STAGES; k++) begin
            xs = src_x[k][N-1-k*CHUNK -: CHUNK];
            ys = src_y[k][N-1-k*CHUNK -: CHUNK];
            if (!src_dec[k] && (xs != ys)) begin
                nxt_dec[k] = 1'b1;
                nxt_lt[k]  = (xs < ys);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld  <= '0;
            dec  <= '0;
            lt   <= '0;
            seen <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                tag[k] <= '0;
                xr[k]  <= '0;
                yr[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    vld[k] <= src_vld[k];
                end
                // Payload only moves with valid data so an idle output keeps its last result.
                if (load[k] && src_vld[k]) begin
                    dec[k] <= nxt_dec[k];
                    lt[k]  <= nxt_lt[k];
                    tag[k] <= src_tag[k];
                    xr[k]  <= src_x[k];
                    yr[k]  <= src_y[k];
                end
            end
            if (load[LAST] && src_vld[LAST]) begin
                seen <= 1'b1;
            end
        end
    end

    // Already-compared operand bits are carried but never read again.
    always_comb begin
        unused_ops = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            unused_ops = unused_ops ^ (^xr[k]) ^ (^yr[k]);
        end
    end

    assign out_valid = vld[LAST];
    assign Less      = dec[LAST] & lt[LAST];
    assign More      = dec[LAST] & ~lt[LAST];
    assign Equal     = seen & ~dec[LAST];
    assign tag_out   = tag[LAST];

endmodule

// File: tb/tb_pipe_magnitude_comparator.sv
// Directed-vector and scoreboard bench for pipe_magnitude_comparator, plus latency checks of other widths.
module tb_pipe_magnitude_comparator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, is_signed, out_valid, out_ready;
    logic        Less, More, Equal;
    logic [15:0] X, Y;
    logic [3:0]  tag_in, tag_out;

    logic        sw_valid;
    logic [31:0] sw_x, sw_y;
    logic [2:0]  sv_rdy, sv_ov, sv_l, sv_m, sv_e;
    logic [3:0]  sv_tag [3];

    always #5 clk = ~clk;

    pipe_magnitude_comparator #(.N(16), .CHUNK(4), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .X(X), .Y(Y), .is_signed(is_signed), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .Less(Less), .More(More), .Equal(Equal), .tag_out(tag_out));

    pipe_magnitude_comparator #(.N(16), .CHUNK(16), .TAG_W(4)) u_s0 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sv_rdy[0]),
        .X(sw_x[15:0]), .Y(sw_y[15:0]), .is_signed(1'b0), .tag_in(4'd7),
        .out_valid(sv_ov[0]), .out_ready(1'b1),
        .Less(sv_l[0]), .More(sv_m[0]), .Equal(sv_e[0]), .tag_out(sv_tag[0]));

    pipe_magnitude_comparator #(.N(32), .CHUNK(8), .TAG_W(4)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sv_rdy[1]),
        .X(sw_x), .Y(sw_y), .is_signed(1'b0), .tag_in(4'd7),
        .out_valid(sv_ov[1]), .out_ready(1'b1),
        .Less(sv_l[1]), .More(sv_m[1]), .Equal(sv_e[1]), .tag_out(sv_tag[1]));

    pipe_magnitude_comparator #(.N(8), .CHUNK(1), .TAG_W(4)) u_s2 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sv_rdy[2]),
        .X(sw_x[7:0]), .Y(sw_y[7:0]), .is_signed(1'b0), .tag_in(4'd7),
        .out_valid(sv_ov[2]), .out_ready(1'b1),
        .Less(sv_l[2]), .More(sv_m[2]), .Equal(sv_e[2]), .tag_out(sv_tag[2]));

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        s;
        logic [3:0]  tag;
        logic [2:0]  lme;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int acc, rx;
    logic [6:0] sb [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] model(input logic [15:0] x, input logic [15:0] y, input logic s);
        if (s) begin
            if ($signed(x) < $signed(y)) return 3'b100;
            if ($signed(x) > $signed(y)) return 3'b010;
            return 3'b001;
        end
        if (x < y) return 3'b100;
        if (x > y) return 3'b010;
        return 3'b001;
    endfunction

    task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic s, input logic [3:0] t);
        in_valid  = 1'b1;
        X         = x;
        Y         = y;
        is_signed = s;
        tag_in    = t;
    endtask

    // One isolated compare: checks acceptance, the 4-cycle latency, the result and the tag.
    task automatic single(input vec_t v, input string nm);
        int lat;
        lat = 0;
        @(negedge clk);
        out_ready = 1'b1;
        drive(v.x, v.y, v.s, v.tag);
        #1 chk({nm, "_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        while (lat < 20 && !out_valid) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'd4);
        chk({nm, "_lme"}, 32'({Less, More, Equal}), 32'(v.lme));
        chk({nm, "_tag"}, 32'(tag_out), 32'(v.tag));
    endtask

    // One cycle of stimulus with scoreboard tracking of both handshakes.
    task automatic step(input logic iv, input logic [15:0] x, input logic [15:0] y,
                        input logic s, input logic [3:0] t, input logic ordy);
        logic [6:0] e;
        @(negedge clk);
        in_valid  = iv;
        X         = x;
        Y         = y;
        is_signed = s;
        tag_in    = t;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_result", 32'({Less, More, Equal, tag_out}), 32'(e));
                chk("sb_onehot", 32'($countones({Less, More, Equal})), 32'd1);
                rx++;
            end
        end
        if (in_valid && in_ready) begin
            sb.push_back({model(x, y, s), t});
            acc++;
        end
    endtask

    vec_t vt [12];
    logic [15:0] bx [8];
    logic [15:0] by [8];

    initial begin
        vt[0]  = '{16'h8000, 16'h7FFF, 1'b0, 4'd1,  3'b010};
        vt[1]  = '{16'h8000, 16'h7FFF, 1'b1, 4'd2,  3'b100};
        vt[2]  = '{16'h1234, 16'h1235, 1'b0, 4'd3,  3'b100};
        vt[3]  = '{16'hFFFF, 16'hFFFF, 1'b0, 4'd4,  3'b001};
        vt[4]  = '{16'h0001, 16'h0000, 1'b0, 4'd5,  3'b010};
        vt[5]  = '{16'hFFFF, 16'h0001, 1'b1, 4'd6,  3'b100};
        vt[6]  = '{16'hFFFF, 16'h0001, 1'b0, 4'd7,  3'b010};
        vt[7]  = '{16'h8000, 16'h8000, 1'b1, 4'd8,  3'b001};
        vt[8]  = '{16'h7FFF, 16'h8000, 1'b1, 4'd9,  3'b010};
        vt[9]  = '{16'h00F0, 16'h00F1, 1'b0, 4'd10, 3'b100};
        vt[10] = '{16'hA5A5, 16'hA5A4, 1'b1, 4'd11, 3'b010};
        vt[11] = '{16'h1234, 16'h1334, 1'b1, 4'd12, 3'b100};
        for (int j = 0; j < 8; j++) begin
            bx[j] = 16'(j * 16'h1111);
            by[j] = 16'h4444;
        end

        rst = 1'b1;
        in_valid = 1'b0; X = '0; Y = '0; is_signed = 1'b0; tag_in = '0; out_ready = 1'b0;
        sw_valid = 1'b0; sw_x = '0; sw_y = '0;
        acc = 0; rx = 0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_lme", 32'({Less, More, Equal}), 32'd0);
        chk("rst_tag", 32'(tag_out), 32'd0);
        rst = 1'b0;
        #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 12; i++) single(vt[i], $sformatf("vec%0d", i));

        // Back-to-back: three results in consecutive cycles, in order.
        @(negedge clk);
        out_ready = 1'b1;
        drive(16'h1234, 16'h1235, 1'b0, 4'd1);
        @(negedge clk);
        drive(16'hFFFF, 16'hFFFF, 1'b0, 4'd2);
        @(negedge clk);
        drive(16'h0001, 16'h0000, 1'b0, 4'd3);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_1", 32'({out_valid, Less, More, Equal, tag_out}), {24'd0, 1'b1, 3'b100, 4'd1});
        @(negedge clk);
        chk("b2b_2", 32'({out_valid, Less, More, Equal, tag_out}), {24'd0, 1'b1, 3'b001, 4'd2});
        @(negedge clk);
        chk("b2b_3", 32'({out_valid, Less, More, Equal, tag_out}), {24'd0, 1'b1, 3'b010, 4'd3});
        @(negedge clk);
        chk("b2b_done", 32'(out_valid), 32'd0);

        // Backpressure: 4 accepted into a stalled pipe, then everything drains in order.
        sb.delete();
        acc = 0; rx = 0;
        for (int c = 0; c < 8; c++)
            step(1'b1, bx[acc], by[acc], acc[0], 4'(acc + 8), 1'b0);
        chk("bp_accepted", 32'(acc), 32'd4);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_a", 32'({Less, More, Equal, tag_out}), 32'({model(bx[0], by[0], 1'b0), 4'd8}));
        for (int c = 0; c < 3; c++)
            step(1'b1, bx[acc], by[acc], acc[0], 4'(acc + 8), 1'b0);
        chk("bp_hold_b", 32'({Less, More, Equal, tag_out}), 32'({model(bx[0], by[0], 1'b0), 4'd8}));
        chk("bp_still_full", 32'(acc), 32'd4);
        for (int c = 0; c < 40 && rx < 8; c++) begin
            if (acc < 8) step(1'b1, bx[acc], by[acc], acc[0], 4'(acc + 8), 1'b1);
            else         step(1'b0, 16'd0, 16'd0, 1'b0, 4'd0, 1'b1);
        end
        chk("bp_received", 32'(rx), 32'd8);
        chk("bp_sent", 32'(acc), 32'd8);

        // Reset with three compares in flight.
        @(negedge clk);
        out_ready = 1'b0;
        drive(16'h0100, 16'h0200, 1'b0, 4'd13);
        @(negedge clk);
        drive(16'h0300, 16'h0200, 1'b0, 4'd14);
        @(negedge clk);
        drive(16'h0050, 16'h0050, 1'b0, 4'd15);
        @(negedge clk);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_lme", 32'({Less, More, Equal}), 32'd0);
        chk("mid_rst_tag", 32'(tag_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        single('{16'd5, 16'd5, 1'b0, 4'd9, 3'b001}, "after_rst");
        sb.delete();

        // Latency of the other geometries.
        begin
            int lat_s [3];
            logic [2:0] res_s [3];
            int exp_lat [3];
            exp_lat[0] = 1; exp_lat[1] = 4; exp_lat[2] = 8;
            for (int i = 0; i < 3; i++) begin
                lat_s[i] = -1;
                res_s[i] = '0;
            end
            @(negedge clk);
            sw_valid = 1'b1; sw_x = 32'd3; sw_y = 32'd5;
            #1 chk("sweep_ready", 32'(sv_rdy), 32'd7);
            @(posedge clk);
            #1 sw_valid = 1'b0;
            for (int n = 1; n <= 12; n++) begin
                @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    if (sv_ov[i] && lat_s[i] < 0) begin
                        lat_s[i] = n;
                        res_s[i] = {sv_l[i], sv_m[i], sv_e[i]};
                    end
                end
            end
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("sweep%0d_latency", i), 32'(lat_s[i]), 32'(exp_lat[i]));
                chk($sformatf("sweep%0d_lme", i), 32'(res_s[i]), 32'b100);
            end
        end

        // Random traffic against the scoreboard.
        acc = 0; rx = 0;
        begin
            logic [15:0] rxv, ryv;
            for (int c = 0; c < 40000 && rx < 10000; c++) begin
                rxv = 16'($urandom);
                ryv = ($urandom_range(0, 3) == 0) ? rxv : 16'($urandom);
                if ($urandom_range(0, 3) == 0) ryv[15:4] = rxv[15:4];
                step((acc < 10000) && ($urandom_range(0, 3) != 0), rxv, ryv,
                     1'($urandom_range(0, 1)), 4'($urandom), $urandom_range(0, 3) != 0);
            end
        end
        chk("rand_received", 32'(rx), 32'd10000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
